// File: rtl/dual_issue_scheduler_pkg.sv
// Shared types and constants for the dual-issue scheduler: pipe classes, ordering tags,
// opcode class masks and the opcode classifier.
package dual_issue_scheduler_pkg;

    typedef enum logic [1:0] {
        PipeClassAny = 2'b00,
        PipeClassMem = 2'b01,
        PipeClassBr  = 2'b10
    } pipe_class_e;

    localparam logic [1:0] TagNone    = 2'b00;
    localparam logic [1:0] TagOlder   = 2'b01;
    localparam logic [1:0] TagYounger = 2'b10;

    localparam logic [5:0] OpClassMask = 6'b110000;
    localparam logic [5:0] OpClassMem  = 6'b100000;
    localparam logic [5:0] OpClassBr   = 6'b110000;

    // Compare/test opcodes that live outside the 11xxxx block but still need the branch pipe.
    localparam logic [5:0] OpCodeCmp   = 6'b001000;
    localparam logic [5:0] OpCodeTest  = 6'b001001;
    localparam logic [5:0] OpCodeCmpi  = 6'b001010;
    localparam logic [5:0] OpCodeTesti = 6'b001011;

    function automatic pipe_class_e op_class(input logic [5:0] opcode);
        pipe_class_e cls;
        cls = PipeClassAny;
        if ((opcode & OpClassMask) == OpClassMem) begin
            cls = PipeClassMem;
        end else if ((opcode & OpClassMask) == OpClassBr) begin
            cls = PipeClassBr;
        end else if (opcode inside {OpCodeCmp, OpCodeTest, OpCodeCmpi, OpCodeTesti}) begin
            cls = PipeClassBr;
        end
        return cls;
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Fetch-side and issue-side signals of the dual-issue scheduler.
// master = fetch/pipe side, slave = scheduler.
interface dual_issue_scheduler_if #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 16
);
    logic                  fetch_valid;
    logic [1:0]            fetch_count;
    logic [INST_WIDTH-1:0] fetch_inst0;
    logic [INST_WIDTH-1:0] fetch_inst1;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  fetch_ready;

    logic                  issue_valid0;
    logic                  issue_valid1;
    logic [INST_WIDTH-1:0] issue_inst0;
    logic [INST_WIDTH-1:0] issue_inst1;
    logic [ADDR_WIDTH-1:0] issue_pc0;
    logic [ADDR_WIDTH-1:0] issue_pc1;
    logic [ID_WIDTH+1:0]   issue_id0;
    logic [ID_WIDTH+1:0]   issue_id1;
    logic                  first;

    modport master (
        output fetch_valid, fetch_count, fetch_inst0, fetch_inst1, fetch_pc,
        input  fetch_ready,
        input  issue_valid0, issue_valid1, issue_inst0, issue_inst1,
        input  issue_pc0, issue_pc1, issue_id0, issue_id1, first
    );

    modport slave (
        input  fetch_valid, fetch_count, fetch_inst0, fetch_inst1, fetch_pc,
        output fetch_ready,
        output issue_valid0, issue_valid1, issue_inst0, issue_inst1,
        output issue_pc0, issue_pc1, issue_id0, issue_id1, first
    );

endinterface

// File: rtl/dual_issue_scheduler_fifo.sv
// In-order instruction queue: up to two writes and zero to two reads per cycle,
// exposing the head entry and the one behind it.
module dual_issue_scheduler_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic [1:0]              wr_count,
    input  logic [INST_WIDTH-1:0]   wr_inst0,
    input  logic [INST_WIDTH-1:0]   wr_inst1,
    input  logic [ADDR_WIDTH-1:0]   wr_pc0,
    input  logic [ADDR_WIDTH-1:0]   wr_pc1,
    input  logic [1:0]              rd_count,
    output logic                    head_valid,
    output logic [INST_WIDTH-1:0]   head_inst,
    output logic [ADDR_WIDTH-1:0]   head_pc,
    output logic                    next_valid,
    output logic [INST_WIDTH-1:0]   next_inst,
    output logic [ADDR_WIDTH-1:0]   next_pc,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_p1;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_p1;
    logic [CntW-1:0] occ_q, occ_d;

    assign wr_ptr_p1 = wr_ptr_q + PtrW'(1);
    assign rd_ptr_p1 = rd_ptr_q + PtrW'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(wr_count);
        rd_ptr_d = rd_ptr_q + PtrW'(rd_count);
        occ_d    = occ_q + CntW'(wr_count) - CntW'(rd_count);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!flush && (wr_count == 2'd1 || wr_count == 2'd2)) begin
            inst_mem[wr_ptr_q] <= wr_inst0;
            pc_mem[wr_ptr_q]   <= wr_pc0;
        end
        if (!flush && wr_count == 2'd2) begin
            inst_mem[wr_ptr_p1] <= wr_inst1;
            pc_mem[wr_ptr_p1]   <= wr_pc1;
        end
    end

    assign head_valid = (occ_q != '0);
    assign next_valid = (occ_q >= CntW'(2));
    assign head_inst  = inst_mem[rd_ptr_q];
    assign head_pc    = pc_mem[rd_ptr_q];
    assign next_inst  = inst_mem[rd_ptr_p1];
    assign next_pc    = pc_mem[rd_ptr_p1];
    assign occupancy  = occ_q;

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: queues fetched instructions and issues up to two per cycle,
// memory ops to pipe 0 and branch/compare ops to pipe 1, with ordering bit and IDs.
module dual_issue_scheduler
    import dual_issue_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic stall,
    input  logic flush,
    dual_issue_scheduler_if.slave bus
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [CntW-1:0]       occupancy;
    logic                  head_valid, next_valid;
    logic [INST_WIDTH-1:0] head_inst, next_inst;
    logic [ADDR_WIDTH-1:0] head_pc, next_pc;
    logic [ADDR_WIDTH-1:0] fetch_pc1;
    logic [1:0]            wr_count, rd_count, deq_count;

    pipe_class_e a_class, b_class;
    logic        issue_a, issue_b, a_pipe1;

    logic                  valid_d [2];
    logic [INST_WIDTH-1:0] inst_d  [2];
    logic [ADDR_WIDTH-1:0] pc_d    [2];
    logic [1:0]            tag_d   [2];
    logic                  first_d;

    logic                  valid_q [2];
    logic [INST_WIDTH-1:0] inst_q  [2];
    logic [ADDR_WIDTH-1:0] pc_q    [2];
    logic [ID_WIDTH+1:0]   id_q    [2];
    logic                  first_q;
    logic [ID_WIDTH-1:0]   cycle_count_q;

    assign fetch_pc1       = bus.fetch_pc + ADDR_WIDTH'(1);
    assign bus.fetch_ready = (occupancy <= CntW'(DEPTH - 2));

    always_comb begin
        wr_count = 2'd0;
        if (bus.fetch_valid && bus.fetch_ready && !flush &&
            (bus.fetch_count == 2'd1 || bus.fetch_count == 2'd2)) begin
            wr_count = bus.fetch_count;
        end
    end

    assign rd_count = (flush || stall) ? 2'd0 : deq_count;

    dual_issue_scheduler_fifo #(
        .DEPTH      (DEPTH),
        .INST_WIDTH (INST_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .wr_count   (wr_count),
        .wr_inst0   (bus.fetch_inst0),
        .wr_inst1   (bus.fetch_inst1),
        .wr_pc0     (bus.fetch_pc),
        .wr_pc1     (fetch_pc1),
        .rd_count   (rd_count),
        .head_valid (head_valid),
        .head_inst  (head_inst),
        .head_pc    (head_pc),
        .next_valid (next_valid),
        .next_inst  (next_inst),
        .next_pc    (next_pc),
        .occupancy  (occupancy)
    );

    always_comb begin
        a_class   = op_class(head_inst[31:26]);
        b_class   = op_class(next_inst[31:26]);
        issue_a   = head_valid;
        issue_b   = head_valid && next_valid &&
                    !(a_class == b_class && a_class != PipeClassAny);
        // An unclassed A gives up pipe 0 when its partner is a memory op.
        a_pipe1   = (a_class == PipeClassBr) ||
                    (issue_b && a_class == PipeClassAny && b_class == PipeClassMem);
        deq_count = {issue_b, issue_a && !issue_b};
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            valid_d[s] = 1'b0;
            inst_d[s]  = '0;
            pc_d[s]    = '0;
            tag_d[s]   = TagNone;
            if (issue_a && (a_pipe1 == (s == 1))) begin
                valid_d[s] = 1'b1;
                inst_d[s]  = head_inst;
                pc_d[s]    = head_pc;
                tag_d[s]   = TagOlder;
            end else if (issue_b && (a_pipe1 != (s == 1))) begin
                valid_d[s] = 1'b1;
                inst_d[s]  = next_inst;
                pc_d[s]    = next_pc;
                tag_d[s]   = TagYounger;
            end
        end
        first_d = !(issue_a && a_pipe1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 2; s++) begin
                valid_q[s] <= 1'b0;
                inst_q[s]  <= '0;
                pc_q[s]    <= '0;
                id_q[s]    <= '0;
            end
            first_q       <= 1'b1;
            cycle_count_q <= '0;
        end else if (flush) begin
            for (int s = 0; s < 2; s++) begin
                valid_q[s] <= 1'b0;
                inst_q[s]  <= '0;
                pc_q[s]    <= '0;
                id_q[s]    <= '0;
            end
            first_q <= 1'b1;
        end else if (!stall) begin
            for (int s = 0; s < 2; s++) begin
                valid_q[s] <= valid_d[s];
                inst_q[s]  <= inst_d[s];
                pc_q[s]    <= pc_d[s];
                id_q[s]    <= valid_d[s] ? {cycle_count_q, tag_d[s]} : '0;
            end
            first_q <= first_d;
            if (issue_a) begin
                cycle_count_q <= cycle_count_q + ID_WIDTH'(1);
            end
        end
    end

    assign bus.issue_valid0 = valid_q[0];
    assign bus.issue_valid1 = valid_q[1];
    assign bus.issue_inst0  = inst_q[0];
    assign bus.issue_inst1  = inst_q[1];
    assign bus.issue_pc0    = pc_q[0];
    assign bus.issue_pc1    = pc_q[1];
    assign bus.issue_id0    = id_q[0];
    assign bus.issue_id1    = id_q[1];
    assign bus.first        = first_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler with a queue-based reference model checked every cycle.
module tb_dual_issue_scheduler;

    localparam logic [31:0] I_ADD = {6'b000001, 26'h0000123};
    localparam logic [31:0] I_LW  = {6'b100000, 26'h0000456};
    localparam logic [31:0] I_JMP = {6'b110000, 26'h0000789};
    localparam logic [31:0] I_CMP = {6'b001000, 26'h0000abc};

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;

    int total = 0;
    int bad = 0;

    dual_issue_scheduler_if #(.INST_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(16)) bus ();

    dual_issue_scheduler #(
        .DEPTH      (8),
        .INST_WIDTH (32),
        .ADDR_WIDTH (16),
        .ID_WIDTH   (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (stall),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [15:0] pc;
    } ent_t;

    ent_t        mq[$];
    int          m_count = 0;
    logic        m_loaded = 1'b0;
    logic        exp_v    [2] = '{1'b0, 1'b0};
    logic [31:0] exp_inst [2] = '{32'd0, 32'd0};
    logic [15:0] exp_pc   [2] = '{16'd0, 16'd0};
    logic [17:0] exp_id   [2] = '{18'd0, 18'd0};
    logic        exp_first = 1'b1;
    logic        exp_ready = 1'b1;

    // 0 = unclassed, 1 = memory, 2 = branch/compare
    function automatic int kind(input logic [31:0] inst);
        logic [5:0] op;
        op = inst[31:26];
        if (op[5:4] == 2'b10) return 1;
        if (op[5:4] == 2'b11) return 2;
        if (op == 6'h08 || op == 6'h09 || op == 6'h0a || op == 6'h0b) return 2;
        return 0;
    endfunction

    task automatic clr_exp();
        for (int s = 0; s < 2; s++) begin
            exp_v[s] = 1'b0;
            exp_inst[s] = '0;
            exp_pc[s] = '0;
            exp_id[s] = '0;
        end
        exp_first = 1'b1;
    endtask

    task automatic put(input int slot, input ent_t e, input logic [1:0] tag);
        exp_v[slot] = 1'b1;
        exp_inst[slot] = e.inst;
        exp_pc[slot] = e.pc;
        exp_id[slot] = {m_count[15:0], tag};
    endtask

    task automatic model_issue();
        ent_t a, b;
        int ka, kb, sa;
        clr_exp();
        if (mq.size() == 0) return;
        a = mq[0];
        ka = kind(a.inst);
        if (mq.size() >= 2) begin
            b = mq[1];
            kb = kind(b.inst);
        end
        if (mq.size() == 1 || (ka == kb && ka != 0)) begin
            sa = (ka == 2) ? 1 : 0;
            put(sa, a, 2'b01);
            void'(mq.pop_front());
        end else begin
            sa = (ka == 2 || kb == 1) ? 1 : 0;
            put(sa, a, 2'b01);
            put(1 - sa, b, 2'b10);
            void'(mq.pop_front());
            void'(mq.pop_front());
        end
        exp_first = (sa == 0);
        m_count++;
    endtask

    always @(posedge clk or negedge reset_n) begin : model
        int   old_size;
        ent_t e;
        if (!reset_n) begin
            mq.delete();
            m_count = 0;
            m_loaded = 1'b0;
            clr_exp();
        end else if (flush) begin
            mq.delete();
            m_loaded = 1'b0;
            clr_exp();
        end else begin
            old_size = mq.size();
            m_loaded = !stall;
            if (!stall) model_issue();
            if (bus.fetch_valid && (8 - old_size) >= 2 &&
                (bus.fetch_count == 2'd1 || bus.fetch_count == 2'd2)) begin
                e.inst = bus.fetch_inst0;
                e.pc = bus.fetch_pc;
                mq.push_back(e);
                if (bus.fetch_count == 2'd2) begin
                    e.inst = bus.fetch_inst1;
                    e.pc = bus.fetch_pc + 16'd1;
                    mq.push_back(e);
                end
            end
        end
        exp_ready = (8 - mq.size()) >= 2;
    end

    // ---------------- per-cycle compare + issued-PC scoreboard ----------------
    logic        sb_en = 1'b0;
    logic [15:0] sb[$];

    always @(negedge clk) begin
        chk("cyc fetch_ready", bus.fetch_ready, exp_ready);
        chk("cyc first", bus.first, exp_first);
        chk("cyc valid0", bus.issue_valid0, exp_v[0]);
        chk("cyc valid1", bus.issue_valid1, exp_v[1]);
        chk("cyc inst0", bus.issue_inst0, exp_inst[0]);
        chk("cyc inst1", bus.issue_inst1, exp_inst[1]);
        chk("cyc pc0", bus.issue_pc0, exp_pc[0]);
        chk("cyc pc1", bus.issue_pc1, exp_pc[1]);
        chk("cyc id0", bus.issue_id0, exp_id[0]);
        chk("cyc id1", bus.issue_id1, exp_id[1]);
        if (sb_en && m_loaded) begin
            if (bus.first) begin
                if (bus.issue_valid0) sb.push_back(bus.issue_pc0);
                if (bus.issue_valid1) sb.push_back(bus.issue_pc1);
            end else begin
                if (bus.issue_valid1) sb.push_back(bus.issue_pc1);
                if (bus.issue_valid0) sb.push_back(bus.issue_pc0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [1:0] c, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [15:0] pc);
        bus.fetch_valid = v;
        bus.fetch_count = c;
        bus.fetch_inst0 = i0;
        bus.fetch_inst1 = i1;
        bus.fetch_pc = pc;
    endtask

    logic [15:0] sb_exp [9] = '{16'h40, 16'h41, 16'h42, 16'h43, 16'h44, 16'h45, 16'h46,
                                16'h48, 16'h49};

    initial begin
        fetch(1'b0, 2'd0, 32'd0, 32'd0, 16'd0);
        #1 reset_n = 1'b0;
        #7;
        chk("reset valid0", bus.issue_valid0, 1'b0);
        chk("reset valid1", bus.issue_valid1, 1'b0);
        chk("reset first", bus.first, 1'b1);
        chk("reset ready", bus.fetch_ready, 1'b1);
        chk("reset id0", bus.issue_id0, 18'd0);
        #4 reset_n = 1'b1;

        // add + lw: lw takes pipe 0, add moves to pipe 1
        fetch(1'b1, 2'd2, I_ADD, I_LW, 16'h10);
        tick();
        fetch(1'b0, 2'd0, 32'd0, 32'd0, 16'd0);
        chk("t1 not yet valid", bus.issue_valid0, 1'b0);
        tick();
        chk("t1 inst0", bus.issue_inst0, I_LW);
        chk("t1 pc0", bus.issue_pc0, 16'h11);
        chk("t1 pc1", bus.issue_pc1, 16'h10);
        chk("t1 first", bus.first, 1'b0);
        chk("t1 id0", bus.issue_id0, 18'h2);
        chk("t1 id1", bus.issue_id1, 18'h1);
        tick();
        chk("t1 idle first", bus.first, 1'b1);

        // lw + lw: two single issues
        fetch(1'b1, 2'd2, I_LW, I_LW, 16'h20);
        tick();
        fetch(1'b0, 2'd0, 32'd0, 32'd0, 16'd0);
        tick();
        chk("t2 pc0", bus.issue_pc0, 16'h20);
        chk("t2 valid1", bus.issue_valid1, 1'b0);
        chk("t2 first", bus.first, 1'b1);
        chk("t2 id0", bus.issue_id0, 18'h5);
        tick();
        chk("t2 pc0 b", bus.issue_pc0, 16'h21);
        chk("t2 id0 b", bus.issue_id0, 18'h9);

        // jmp + add, then cmp + jmp
        fetch(1'b1, 2'd2, I_JMP, I_ADD, 16'h30);
        tick();
        fetch(1'b0, 2'd0, 32'd0, 32'd0, 16'd0);
        tick();
        chk("t3 inst1", bus.issue_inst1, I_JMP);
        chk("t3 pc1", bus.issue_pc1, 16'h30);
        chk("t3 pc0", bus.issue_pc0, 16'h31);
        chk("t3 first", bus.first, 1'b0);
        chk("t3 id1", bus.issue_id1, 18'hd);
        fetch(1'b1, 2'd2, I_CMP, I_JMP, 16'h38);
        tick();
        fetch(1'b0, 2'd0, 32'd0, 32'd0, 16'd0);
        tick();
        chk("t3 cmp valid1", bus.issue_valid1, 1'b1);
        chk("t3 cmp pc1", bus.issue_pc1, 16'h38);
        chk("t3 cmp valid0", bus.issue_valid0, 1'b0);
        chk("t3 cmp first", bus.first, 1'b0);
        chk("t3 cmp id1", bus.issue_id1, 18'h11);
        tick();
        chk("t3 jmp pc1", bus.issue_pc1, 16'h39);

        // fill to 7 under stall, then release
        stall = 1'b1;
        fetch(1'b1, 2'd2, I_LW, I_JMP, 16'h40);
        tick();
        fetch(1'b1, 2'd2, I_LW, I_JMP, 16'h42);
        tick();
        fetch(1'b1, 2'd2, I_LW, I_JMP, 16'h44);
        tick();
        chk("t4 ready at 6", bus.fetch_ready, 1'b1);
        fetch(1'b1, 2'd1, I_LW, I_LW, 16'h46);
        tick();
        chk("t4 ready at 7", bus.fetch_ready, 1'b0);
        fetch(1'b1, 2'd2, I_LW, I_JMP, 16'h48);
        tick();
        chk("t4 held pc1", bus.issue_pc1, 16'h39);
        chk("t4 still full", bus.fetch_ready, 1'b0);
        sb_en = 1'b1;
        stall = 1'b0;
        tick();
        chk("t4 rel pc0", bus.issue_pc0, 16'h40);
        chk("t4 rel pc1", bus.issue_pc1, 16'h41);
        chk("t4 rel ready", bus.fetch_ready, 1'b1);
        tick();
        fetch(1'b0, 2'd0, 32'd0, 32'd0, 16'd0);
        repeat (6) tick();
        sb_en = 1'b0;
        chk("t4 sb count", sb.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < sb.size()) chk("t4 sb pc", sb[i], sb_exp[i]);
        end

        // flush at occupancy 5 with stall and fetch
        fetch(1'b1, 2'd2, I_ADD, I_LW, 16'h50);
        tick();
        fetch(1'b1, 2'd2, I_ADD, I_LW, 16'h52);
        tick();
        stall = 1'b1;
        fetch(1'b1, 2'd2, I_ADD, I_LW, 16'h54);
        tick();
        fetch(1'b1, 2'd1, I_ADD, I_LW, 16'h56);
        tick();
        chk("t5 held valid0", bus.issue_valid0, 1'b1);
        flush = 1'b1;
        fetch(1'b1, 2'd2, I_LW, I_JMP, 16'h60);
        tick();
        chk("t5 valid0", bus.issue_valid0, 1'b0);
        chk("t5 valid1", bus.issue_valid1, 1'b0);
        chk("t5 first", bus.first, 1'b1);
        chk("t5 inst0", bus.issue_inst0, 32'd0);
        chk("t5 ready", bus.fetch_ready, 1'b1);
        flush = 1'b0;
        stall = 1'b0;
        fetch(1'b0, 2'd0, 32'd0, 32'd0, 16'd0);
        repeat (2) tick();
        chk("t5 empty valid0", bus.issue_valid0, 1'b0);
        chk("t5 empty valid1", bus.issue_valid1, 1'b0);

        // fetch_count = 3 is ignored
        fetch(1'b1, 2'd3, I_LW, I_JMP, 16'h64);
        tick();
        fetch(1'b0, 2'd0, 32'd0, 32'd0, 16'd0);
        tick();
        chk("t5 cnt3 valid0", bus.issue_valid0, 1'b0);

        // asynchronous reset mid-stream
        fetch(1'b1, 2'd2, I_ADD, I_LW, 16'h70);
        tick();
        fetch(1'b1, 2'd2, I_ADD, I_LW, 16'h72);
        tick();
        fetch(1'b0, 2'd0, 32'd0, 32'd0, 16'd0);
        chk("t6 pre valid0", bus.issue_valid0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6 rst valid0", bus.issue_valid0, 1'b0);
        chk("t6 rst valid1", bus.issue_valid1, 1'b0);
        chk("t6 rst pc0", bus.issue_pc0, 16'd0);
        chk("t6 rst first", bus.first, 1'b1);
        chk("t6 rst ready", bus.fetch_ready, 1'b1);
        #2 reset_n = 1'b1;
        fetch(1'b1, 2'd2, I_JMP, I_LW, 16'h80);
        tick();
        fetch(1'b0, 2'd0, 32'd0, 32'd0, 16'd0);
        tick();
        chk("t6 pc1", bus.issue_pc1, 16'h80);
        chk("t6 pc0", bus.issue_pc0, 16'h81);
        chk("t6 id1", bus.issue_id1, 18'h1);
        chk("t6 id0", bus.issue_id0, 18'h2);
        tick();
        chk("t6 no stale", bus.issue_valid0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Sits between the fetch stage and the IF/ID registers of the two execution pipes.
- Buffers fetched instructions in a small in-order queue.
- Each cycle, issues up to two of the oldest queued instructions, steering memory ops to pipe 0 and branch/compare ops to pipe 1.
- Produces the `first` ordering bit and the instruction IDs that the hazard detection logic consumes.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 4.
- INST_WIDTH, 32, instruction width.
- ADDR_WIDTH, 16, PC width.
- ID_WIDTH, 16, cycle-count portion of the instruction ID; full ID is ID_WIDTH+2 bits.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- fetch_valid  in  1  fetch presents instructions.
- fetch_count  in  2  number of valid fetch instructions, 1 or 2; 0 and 3 are ignored.
- fetch_inst0  in  INST_WIDTH  older fetched instruction.
- fetch_inst1  in  INST_WIDTH  younger fetched instruction.
- fetch_pc  in  ADDR_WIDTH  PC of fetch_inst0; fetch_inst1 is at fetch_pc+1.
- fetch_ready  out  1  queue can accept two entries.
- stall  in  1  hold issue registers; no dequeue.
- flush  in  1  discard queue and issued instructions.
- issue_valid0, issue_valid1  out  1 each  slot holds a real instruction.
- issue_inst0, issue_inst1  out  INST_WIDTH  issued instruction; 0 (NOP) when slot is invalid.
- issue_pc0, issue_pc1  out  ADDR_WIDTH  PC of slot; 0 when invalid.
- issue_id0, issue_id1  out  ID_WIDTH+2  {cycle_count, tag}.
- first  out  1  1 = slot 0 holds the older instruction.

Behaviour:
- Reset (async, reset_n=0):
  - pointers, occupancy and cycle_count = 0;
  - issue_valid* = 0, issue_inst*/pc*/id* = 0;
  - first = 1;
  - fetch_ready = 1.
- Occupancy register is clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- fetch_ready = (DEPTH - occupancy) >= 2, combinational from registered occupancy.
- Enqueue occurs when fetch_valid && fetch_ready:
  - writes fetch_count entries {inst, pc};
  - entry 1 pc = fetch_pc+1, truncated to ADDR_WIDTH.
- Opcode = inst[31:26]. Classes:
  - MEM: 10xxxx.
  - BR: 11xxxx, plus CMP/TEST/CMPI/TESTI.
  - ANY: everything else, including 000000.
- Issue decision uses A = queue head and B = head+1, registered state only. An entry enqueued at edge N can issue at edge N+1 at the earliest.
  - Empty queue: nothing issues.
  - Only A present:
    - A goes to pipe 1 if A is BR, otherwise to pipe 0;
    - the other slot is invalid;
    - dequeue 1.
  - A and B with the same non-ANY class (MEM/MEM or BR/BR): issue A alone, as above; dequeue 1.
  - Otherwise dual issue, dequeue 2:
    - A goes to its class pipe (ANY goes to pipe 0);
    - B goes to the remaining pipe.
  - first = 1 iff A is in slot 0. When only one instruction issues, first = (that instruction is in slot 0).
- Tags: the older instruction gets tag 2'b01, the younger gets 2'b10; an invalid slot gets 2'b00.
- cycle_count increments on each non-stall edge where at least one instruction issues. IDs use the pre-increment value.
- stall=1 (and flush=0):
  - issue registers and first hold;
  - no dequeue;
  - enqueue still permitted.
- flush=1, which has priority over stall and fetch:
  - next edge: occupancy = 0 and pointers = 0;
  - issue_valid* = 0, outputs zeroed, first = 1;
  - same-cycle fetch is dropped;
  - cycle_count is not reset.
- Simultaneous enqueue and dequeue: occupancy_next = occupancy + enq - deq. Dequeue never exceeds occupancy.
- A fetch with fetch_ready=0 is not consumed; fetch must hold.

Decomposition:
- defines.vh additions:
  - PIPE_CLASS_ANY/MEM/BR encodings;
  - tags TAG_OLDER=2'b01, TAG_YOUNGER=2'b10;
  - opcode class masks.
  Existing OP_CODE_CMP/TEST/CMPI/TESTI are reused.
- Sub-module issue_fifo:
  - circular buffer with 2-wide write and 0/1/2 read;
  - exposes head and head+1 entries with their valid bits, and occupancy.
- The scheduler holds the steering logic, issue registers, first and cycle_count.

Test Plan:
- Reset, then fetch add(000001)+lw(100000) at pc=0x10 -> next edge: slot0 = lw pc 0x11, slot1 = add pc 0x10, first=0, ids {0,10}/{0,01}, cycle_count=1.
- Fetch lw+lw at pc=0x20 -> edge 1: slot0 = lw pc 0x20, valid1=0, first=1; edge 2: slot0 = lw pc 0x21.
- Fetch jmp(110000)+add at pc=0x30 -> slot1 = jmp pc 0x30, slot0 = add pc 0x31, first=0; cmp+jmp -> single issue of cmp to slot1.
- Fill to occupancy 7 with stall=1 -> fetch_ready=0 at occupancy 7; release stall -> dequeue 2, fetch_ready returns to 1; no entry is lost or duplicated (checked with a PC scoreboard).
- With occupancy 5 and stall=1, assert flush alongside fetch_valid -> next edge: occupancy=0, valid0=valid1=0, first=1, fetched pair absent afterwards.
- Assert reset_n low mid-stream between clock edges -> outputs zero immediately; after release, first issue carries pc from the next fetch only, with cycle_count restarting at 0.
